scandoubler: RTL and testbench
==============================

// Module: scandoubler
// PURPOSE
//  Line doubler that sits directly downstream of the horizontal colour-blend stage. Stores each
//  15 kHz input line and replays it twice at twice the pixel rate, for 31 kHz VGA output.
//  Optional scanline attenuation darkens the second replay. Feeds the OSD/VGA output stage.
// PARAMETERS
//  VIDEO_DEPTH  8     bits per colour channel
//  MAX_PIX      1024  line buffer depth (pixels per input line); power of two
//  PIX_W        10    log2(MAX_PIX); line counter width
// PORTS
//  clk         in   1              system clock; all logic on posedge
//  reset_n     in   1              asynchronous reset, active-low
//  pix_ce      in   1              input pixel strobe (1 clk wide)
//  pix_ce_x2   in   1              output pixel strobe at 2x pix_ce rate; coincides with every pix_ce
//  enable      in   1              1 = double lines; 0 = bypass
//  scanlines   in   2              second-replay attenuation: 0 none, 1 25%, 2 50%, 3 75%
//  hblank,vblank,hs,vs in 1        input timing; active-high
//  red,green,blue in VIDEO_DEPTH   input colour
//  hblank_out,vblank_out,hs_out,vs_out out 1  output timing, registered
//  red_out,green_out,blue_out out VIDEO_DEPTH output colour, registered
// BEHAVIOUR
//  Reset: every output 0; wr_cnt, rd_cnt and line_len are 0; buf_sel=0; hs_len=0; vs/vblank line
//  delays 0; replay=0. RAM contents are not reset.
//  Write side (on pix_ce):
//   - Write {hblank,r,g,b} to buffer[buf_sel] at wr_cnt.
//   - wr_cnt increments and saturates at MAX_PIX-1; further writes are suppressed.
//   - While hs=1, hs_cnt counts pix_ce.
//  Input hs rising edge (hs=1, hs_d=0, sampled on pix_ce):
//   - line_len <= wr_cnt+1, saturated to MAX_PIX.
//   - hs_len <= hs_cnt of the previous pulse.
//   - buf_sel toggles; wr_cnt <= 0; hs_cnt <= 0.
//   - vs_line <= vs and vbl_line <= vblank (one-line delay).
//   - Read side restarts: rd_cnt <= 0, replay <= 0.
//  Read side (on pix_ce_x2), reads buffer[~buf_sel]:
//   - rd_cnt increments.
//   - At rd_cnt==line_len-1, rd_cnt wraps to 0 and replay <= 1.
//   - If line_len==0 (no hs seen yet), rd_cnt free-runs modulo MAX_PIX.
//   - Simultaneous hs edge and wrap: the hs edge restart wins.
//  Output timing:
//   - hs_out = (rd_cnt < hs_len); sync width in pix_ce_x2 ticks equals input width in pix_ce ticks.
//   - vs_out = vs_line; vblank_out = vbl_line; hblank_out = stored hblank bit.
//  Colour arithmetic: c = stored value; forced to 0 when stored hblank or vbl_line is 1.
//   - If replay=1: scanlines 1 -> c - (c>>2); 2 -> c>>1; 3 -> c>>2. No overflow is possible.
//   - Full width is kept; truncation is by shift only.
//  Latency: RAM read is registered. Outputs update 2 clk after the pix_ce_x2 that advances rd_cnt
//   and hold between strobes.
//  enable=0: outputs <= inputs on every pix_ce, 1 pix_ce latency, no attenuation. Line
//   bookkeeping continues, so re-enable takes effect cleanly at the next hs edge.
//  Reset asserted mid-line: outputs drop to 0 immediately. The first valid doubled line is the
//   one after the second hs edge following reset release.
// STRUCTURE
//  Sub-module line_ram: simple dual-port RAM.
//   - Depth 2*MAX_PIX; address {sel,idx}; data width 3*VIDEO_DEPTH+1.
//   - One write port; one registered read port; no reset.
//  Shared include video_defs.vh: SCANLINE_* codes (2'd0..2'd3) and the RAM word field offsets
//   (HBL_BIT, R/G/B slices). The cofi and OSD stages use the same file.
//  Top level holds the counters, hs edge detect, line-delay registers and the attenuation mux.
// TESTING
//  1. Line of 320 px, hs 24 px, enable=1, scanlines=0 -> each line appears twice.
//     Each output line is 320 pix_ce_x2 ticks long, hs_out is 24 ticks, pixel data matches.
//  2. scanlines=1/2/3, constant red=8'hC8 -> second replay red_out = 8'h96 / 8'h64 / 8'h32.
//     First replay stays 8'hC8.
//  3. Input line of 1100 px with MAX_PIX=1024 -> line_len saturates at 1024; no write past
//     address 1023; replay wraps after 1024 ticks.
//  4. vs pulse on input line N -> vs_out is high during both replays of line N+1 only.
//     Blanked lines output colour 0.
//  5. enable=0 -> outputs equal inputs delayed by exactly 1 pix_ce.
//     Toggling enable to 1 mid-line gives doubled output from the next hs edge.
//  6. Assert reset_n=0 mid-line -> all outputs 0 within 1 clk, asynchronously.
//     After release, no hs_out pulse appears before the first input hs edge.

Source files
------------

// File: rtl/scandoubler_pkg.sv
// Shared constants for the scandoubler: default geometry, scanline codes and
// the field layout of a line-buffer word {hblank, red, green, blue}.
package scandoubler_pkg;

  localparam int DEF_VIDEO_DEPTH = 8;
  localparam int DEF_MAX_PIX     = 1024;
  localparam int DEF_PIX_W       = 10;

  typedef enum logic [1:0] {
    SCANLINE_NONE = 2'd0,
    SCANLINE_25   = 2'd1,
    SCANLINE_50   = 2'd2,
    SCANLINE_75   = 2'd3
  } scanline_e;

  function automatic int word_w(input int depth);
    return 3 * depth + 1;
  endfunction

  function automatic int hbl_bit(input int depth);
    return 3 * depth;
  endfunction

  function automatic int red_lsb(input int depth);
    return 2 * depth;
  endfunction

  function automatic int green_lsb(input int depth);
    return depth;
  endfunction

endpackage

// File: rtl/scandoubler_line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
// Holds two lines selected by the address MSB; contents are never reset.
module scandoubler_line_ram #(
  parameter int AW = 11,
  parameter int DW = 25
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/scandoubler.sv
// 15 kHz to 31 kHz line doubler: each input line is captured into one half of
// the line buffer and replayed twice from the other half at the x2 pixel rate.
module scandoubler
  import scandoubler_pkg::*;
#(
  parameter int VIDEO_DEPTH = DEF_VIDEO_DEPTH,
  parameter int MAX_PIX     = DEF_MAX_PIX,
  parameter int PIX_W       = DEF_PIX_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pix_ce,
  input  logic                   pix_ce_x2,
  input  logic                   enable,
  input  logic [1:0]             scanlines,
  input  logic                   hblank,
  input  logic                   vblank,
  input  logic                   hs,
  input  logic                   vs,
  input  logic [VIDEO_DEPTH-1:0] red,
  input  logic [VIDEO_DEPTH-1:0] green,
  input  logic [VIDEO_DEPTH-1:0] blue,
  output logic                   hblank_out,
  output logic                   vblank_out,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic [VIDEO_DEPTH-1:0] red_out,
  output logic [VIDEO_DEPTH-1:0] green_out,
  output logic [VIDEO_DEPTH-1:0] blue_out
);

  localparam int WORD_W = word_w(VIDEO_DEPTH);
  localparam int HBL    = hbl_bit(VIDEO_DEPTH);
  localparam int R_LSB  = red_lsb(VIDEO_DEPTH);
  localparam int G_LSB  = green_lsb(VIDEO_DEPTH);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(MAX_PIX - 1);
  localparam logic [PIX_W:0]   ONE      = (PIX_W+1)'(1);

  logic [PIX_W-1:0]  wr_cnt, rd_cnt;
  logic [PIX_W:0]    line_len, hs_cnt, hs_len;
  logic              wr_full, buf_sel, hs_d, replay, vs_line, vbl_line;
  logic              hs_edge, ram_we;
  logic [WORD_W-1:0] rd_word;
  logic              x2_d1, x2_d2;
  logic              hs_cmp_d, replay_d, vs_line_d, vbl_line_d;

  function automatic logic [VIDEO_DEPTH-1:0] shade(
    input logic [VIDEO_DEPTH-1:0] c,
    input logic                   blank,
    input logic                   dim,
    input logic [1:0]             mode
  );
    logic [VIDEO_DEPTH-1:0] v;
    v = c;
    if (blank) begin
      v = '0;
    end else if (dim) begin
      case (scanline_e'(mode))
        SCANLINE_25: v = c - (c >> 2);
        SCANLINE_50: v = c >> 1;
        SCANLINE_75: v = c >> 2;
        default:     v = c;
      endcase
    end
    return v;
  endfunction

  assign hs_edge = pix_ce & hs & ~hs_d;
  assign ram_we  = pix_ce & ~wr_full;

  scandoubler_line_ram #(.AW(PIX_W + 1), .DW(WORD_W)) u_line_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({buf_sel, wr_cnt}),
    .wdata ({hblank, red, green, blue}),
    .raddr ({~buf_sel, rd_cnt}),
    .rdata (rd_word)
  );

  // The edge strobe itself belongs to the line being closed, so line_len counts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt   <= '0;
      wr_full  <= 1'b0;
      line_len <= '0;
      buf_sel  <= 1'b0;
      hs_d     <= 1'b0;
      hs_cnt   <= '0;
      hs_len   <= '0;
      vs_line  <= 1'b0;
      vbl_line <= 1'b0;
    end else if (pix_ce) begin
      hs_d <= hs;
      if (hs_edge) begin
        line_len <= {1'b0, wr_cnt} + ONE;
        hs_len   <= hs_cnt;
        hs_cnt   <= ONE;
        buf_sel  <= ~buf_sel;
        wr_cnt   <= '0;
        wr_full  <= 1'b0;
        vs_line  <= vs;
        vbl_line <= vblank;
      end else begin
        if (hs && hs_cnt != '1) hs_cnt <= hs_cnt + ONE;
        if (!wr_full) begin
          if (wr_cnt == PIX_LAST) wr_full <= 1'b1;
          else                    wr_cnt  <= wr_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt <= '0;
      replay <= 1'b0;
    end else if (hs_edge) begin
      rd_cnt <= '0;
      replay <= 1'b0;
    end else if (pix_ce_x2) begin
      if (line_len != '0 && {1'b0, rd_cnt} == line_len - ONE) begin
        rd_cnt <= '0;
        replay <= 1'b1;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Side-band state is aligned with the registered RAM read one clk after the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x2_d1      <= 1'b0;
      x2_d2      <= 1'b0;
      hs_cmp_d   <= 1'b0;
      replay_d   <= 1'b0;
      vs_line_d  <= 1'b0;
      vbl_line_d <= 1'b0;
    end else begin
      x2_d1 <= pix_ce_x2;
      x2_d2 <= x2_d1;
      if (x2_d1) begin
        hs_cmp_d   <= ({1'b0, rd_cnt} < hs_len);
        replay_d   <= replay;
        vs_line_d  <= vs_line;
        vbl_line_d <= vbl_line;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hblank_out <= 1'b0;
      vblank_out <= 1'b0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      red_out    <= '0;
      green_out  <= '0;
      blue_out   <= '0;
    end else if (!enable) begin
      if (pix_ce) begin
        hblank_out <= hblank;
        vblank_out <= vblank;
        hs_out     <= hs;
        vs_out     <= vs;
        red_out    <= red;
        green_out  <= green;
        blue_out   <= blue;
      end
    end else if (x2_d2) begin
      hblank_out <= rd_word[HBL];
      vblank_out <= vbl_line_d;
      hs_out     <= hs_cmp_d;
      vs_out     <= vs_line_d;
      red_out    <= shade(rd_word[R_LSB +: VIDEO_DEPTH], rd_word[HBL] | vbl_line_d, replay_d, scanlines);
      green_out  <= shade(rd_word[G_LSB +: VIDEO_DEPTH], rd_word[HBL] | vbl_line_d, replay_d, scanlines);
      blue_out   <= shade(rd_word[0 +: VIDEO_DEPTH], rd_word[HBL] | vbl_line_d, replay_d, scanlines);
    end
  end

endmodule

// File: tb/tb_scandoubler.sv
// Self-checking bench for scandoubler: random video lines against a line-level
// reference model that predicts every doubled and bypassed output pixel.
module tb_scandoubler;

  localparam int MAXP = 1024;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic       pix_ce_x2 = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] scanlines = 2'd0;
  logic       hblank = 1'b0, vblank = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic       hblank_out, vblank_out, hs_out, vs_out;
  logic [7:0] red_out, green_out, blue_out;

  int checks = 0;
  int errors = 0;
  int n_rep2 = 0;

  scandoubler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_ce     (pix_ce),
    .pix_ce_x2  (pix_ce_x2),
    .enable     (enable),
    .scanlines  (scanlines),
    .hblank     (hblank),
    .vblank     (vblank),
    .hs         (hs),
    .vs         (vs),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hblank_out (hblank_out),
    .vblank_out (vblank_out),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .red_out    (red_out),
    .green_out  (green_out),
    .blue_out   (blue_out)
  );

  always #5 clk = ~clk;

  // pix_ce every 4 clk, pix_ce_x2 every 2 clk, aligned with pix_ce
  logic [1:0] ph = 2'd3;
  always @(posedge clk) begin
    #1;
    ph = ph + 2'd1;
    pix_ce = (ph == 2'd0);
    pix_ce_x2 = ~ph[0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  typedef struct packed {
    logic       hbl;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  typedef struct {
    int   due;
    bit   dbl;
    bit   repl;
    logic hs;
    logic vs;
    logic vbl;
    pix_t p;
  } exp_t;

  pix_t cur_q[$];
  pix_t rep_q[$];
  exp_t pend[$];
  exp_t keep[$];
  exp_t e_new;
  int   rep_len = 0, rep_hs = 0, tick = 0, edges = 0, cur_hs_w = 0, cyc = 0, idx = 0;
  logic rep_vs = 1'b0, rep_vbl = 1'b0, hs_prev = 1'b0, edge_now = 1'b0;
  logic en_now = 1'b1;
  logic [1:0] sl_now = 2'd0;
  logic [7:0] sl_red_tbl [4] = '{8'hC8, 8'h96, 8'h64, 8'h32};

  function automatic logic [7:0] exp_col(input logic [7:0] c, input logic blank,
                                         input logic dim, input logic [1:0] sl);
    int v;
    if (blank) return 8'd0;
    if (!dim) return c;
    case (sl)
      2'd1:    v = c - c / 4;
      2'd2:    v = c / 2;
      2'd3:    v = c / 4;
      default: v = c;
    endcase
    return 8'(v);
  endfunction

  // Reference model: a line is everything written since the last hs rising edge,
  // edge strobe included; it is replayed from tick 0 with period min(len, MAXP).
  always @(posedge clk) begin
    cyc++;
    en_now = enable;
    sl_now = scanlines;
    if (!reset_n) begin
      cur_q.delete();
      rep_q.delete();
      pend.delete();
      rep_len = 0; rep_hs = 0; tick = 0; edges = 0; cur_hs_w = 0;
      rep_vs = 1'b0; rep_vbl = 1'b0; hs_prev = 1'b0;
    end else begin
      edge_now = pix_ce && hs && !hs_prev;
      if (pix_ce) begin
        cur_q.push_back(pix_t'({hblank, red, green, blue}));
        if (!enable) begin
          e_new.due = cyc; e_new.dbl = 1'b0; e_new.repl = 1'b0;
          e_new.hs = hs; e_new.vs = vs; e_new.vbl = vblank;
          e_new.p = pix_t'({hblank, red, green, blue});
          pend.push_back(e_new);
        end
        if (edge_now) begin
          rep_q = cur_q;
          cur_q.delete();
          rep_len = (rep_q.size() > MAXP) ? MAXP : rep_q.size();
          rep_hs = cur_hs_w;
          cur_hs_w = 1;
          rep_vs = vs;
          rep_vbl = vblank;
          edges++;
        end else if (hs) begin
          cur_hs_w++;
        end
        hs_prev = hs;
      end
      if (pix_ce_x2) begin
        if (edge_now) tick = 0;
        else tick++;
        if (edges >= 2 && enable) begin
          idx = tick % rep_len;
          e_new.due = cyc + 2; e_new.dbl = 1'b1; e_new.repl = (tick >= rep_len);
          e_new.hs = (idx < rep_hs); e_new.vs = rep_vs; e_new.vbl = rep_vbl;
          e_new.p = rep_q[idx];
          pend.push_back(e_new);
        end
      end
    end
  end

  task automatic check_entry(input exp_t e);
    logic [31:0] got, want;
    logic        blank;
    got = {4'd0, hblank_out, vblank_out, hs_out, vs_out, red_out, green_out, blue_out};
    if (!e.dbl) begin
      if (!en_now) begin
        want = {4'd0, e.p.hbl, e.vbl, e.hs, e.vs, e.p.r, e.p.g, e.p.b};
        chk("bypass", got, want);
      end
    end else if (en_now) begin
      blank = e.p.hbl | e.vbl;
      want = {4'd0, e.p.hbl, e.vbl, e.hs, e.vs,
              exp_col(e.p.r, blank, e.repl, sl_now),
              exp_col(e.p.g, blank, e.repl, sl_now),
              exp_col(e.p.b, blank, e.repl, sl_now)};
      chk(e.repl ? "replay2" : "replay1", got, want);
      if (e.repl) n_rep2++;
      if (!blank && e.p.r == 8'hC8)
        chk("sl_red", {24'd0, red_out}, {24'd0, e.repl ? sl_red_tbl[sl_now] : 8'hC8});
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      keep.delete();
      foreach (pend[i]) begin
        if (pend[i].due > cyc) keep.push_back(pend[i]);
        else if (pend[i].due == cyc) check_entry(pend[i]);
      end
      pend = keep;
    end
  end

  task automatic put_pix(input logic h, input logic hb, input logic v, input logic vb,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    do begin
      @(posedge clk);
      #2;
    end while (!pix_ce);
    hs = h; hblank = hb; vs = v; vblank = vb; red = r; green = g; blue = b;
  endtask

  task automatic drive_line(input int len, input int hs_w, input logic v, input logic vb,
                            input logic cred, input int first, input int last);
    for (int p = first; p < last; p++) begin
      logic [7:0] r;
      r = cred ? 8'hC8 : 8'($urandom);
      put_pix(p < hs_w, (p < hs_w + 16) || (p >= len - 8), v, vb, r,
              8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {4'd0, hblank_out, vblank_out, hs_out, vs_out, red_out, green_out, blue_out}, 32'd0);
    reset_n = 1'b1;

    // plain doubling, 320 px lines with 24 px sync
    enable = 1'b1;
    scanlines = 2'd0;
    for (int n = 0; n < 4; n++) drive_line(320, 24, 1'b0, 1'b0, 1'b0, 0, 320);

    // scanline attenuation with constant red
    for (int sl = 1; sl < 4; sl++) begin
      scanlines = 2'(sl);
      for (int n = 0; n < 2; n++) drive_line(320, 24, 1'b0, 1'b0, 1'b1, 0, 320);
    end

    // overlong lines saturate the buffer
    scanlines = 2'd0;
    for (int n = 0; n < 2; n++) drive_line(1100, 24, 1'b0, 1'b0, 1'b0, 0, 1100);
    drive_line(320, 24, 1'b0, 1'b0, 1'b0, 0, 320);

    // vertical sync and blanking carried one line late
    for (int n = 0; n < 5; n++) drive_line(320, 24, (n == 1), (n < 3), 1'b0, 0, 320);

    // bypass, then re-enable mid-line
    enable = 1'b0;
    for (int n = 0; n < 3; n++) drive_line(320, 24, (n == 1), 1'b0, 1'b0, 0, 320);
    drive_line(320, 24, 1'b0, 1'b0, 1'b0, 0, 160);
    enable = 1'b1;
    drive_line(320, 24, 1'b0, 1'b0, 1'b0, 160, 320);
    for (int n = 0; n < 3; n++) drive_line(320, 24, 1'b0, 1'b0, 1'b0, 0, 320);

    // asynchronous reset mid-line
    drive_line(320, 24, 1'b0, 1'b0, 1'b0, 0, 160);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_async", {4'd0, hblank_out, vblank_out, hs_out, vs_out, red_out, green_out, blue_out}, 32'd0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int p = 0; p < 200; p++) begin
      put_pix(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
      chk("hs_after_rst", {31'd0, hs_out}, 32'd0);
    end

    // random mix after recovery
    for (int n = 0; n < 5; n++) begin
      scanlines = 2'($urandom_range(0, 3));
      drive_line(300 + 4 * n, 16 + n, 1'($urandom), 1'b0, 1'b0, 0, 300 + 4 * n);
    end

    repeat (16) @(posedge clk);
    chk("replay2_seen", {31'd0, n_rep2 > 0}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
